// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter interface.
// Groups the three result sources (valid/tag/value/address offers and the
// per-source accept flags) and the registered broadcast bus.
//   master : the producer side (functional units) and bus consumers
//   slave  : the arbiter itself
interface cdb_arbiter_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic [2:0]        src_valid;
  logic [TAG_W-1:0]  src_tag0;
  logic [TAG_W-1:0]  src_tag1;
  logic [TAG_W-1:0]  src_tag2;
  logic [DATA_W-1:0] src_val0;
  logic [DATA_W-1:0] src_val1;
  logic [DATA_W-1:0] src_val2;
  logic [DATA_W-1:0] src_addr0;
  logic [DATA_W-1:0] src_addr1;
  logic [DATA_W-1:0] src_addr2;
  logic [2:0]        src_ready;
  logic              cdb_active;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_val;
  logic [DATA_W-1:0] cdb_addr;

  modport master (
    output src_valid, src_tag0, src_tag1, src_tag2,
           src_val0, src_val1, src_val2,
           src_addr0, src_addr1, src_addr2,
    input  src_ready, cdb_active, cdb_tag, cdb_val, cdb_addr
  );

  modport slave (
    input  src_valid, src_tag0, src_tag1, src_tag2,
           src_val0, src_val1, src_val2,
           src_addr0, src_addr1, src_addr2,
    output src_ready, cdb_active, cdb_tag, cdb_val, cdb_addr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter.
// Three result sources (ALU RS, load/store buffer, branch unit) each own one
// holding entry. Valid entries are granted round-robin, one per cycle, onto a
// registered broadcast bus (cdb_active pulses for one cycle per grant).
// Ports:
//   clk_in  - clock, rising edge
//   rst_in  - asynchronous active-high reset
//   rdy_in  - global ready; low freezes every piece of state
//   flush   - synchronous misprediction flush (drops held entries)
//   bus     - cdb_arbiter_if.slave: source offers, src_ready, cdb_* outputs
// Tag value 0 is the None tag and is never captured or broadcast.
module cdb_arbiter #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  logic [2:0]        hold_valid_r;
  logic [TAG_W-1:0]  hold_tag_r  [3];
  logic [DATA_W-1:0] hold_val_r  [3];
  logic [DATA_W-1:0] hold_addr_r [3];
  logic [1:0]        rr_ptr_r;

  logic              cdb_active_r;
  logic [TAG_W-1:0]  cdb_tag_r;
  logic [DATA_W-1:0] cdb_val_r;
  logic [DATA_W-1:0] cdb_addr_r;

  logic [TAG_W-1:0]  src_tag_s  [3];
  logic [DATA_W-1:0] src_val_s  [3];
  logic [DATA_W-1:0] src_addr_s [3];
  logic [2:0]        grant_s;
  logic [2:0]        src_ready_s;
  logic [2:0]        accept_s;
  logic [1:0]        rr_next_s;
  logic [TAG_W-1:0]  sel_tag_s;
  logic [DATA_W-1:0] sel_val_s;
  logic [DATA_W-1:0] sel_addr_s;

  assign src_tag_s[0]  = bus.src_tag0;
  assign src_tag_s[1]  = bus.src_tag1;
  assign src_tag_s[2]  = bus.src_tag2;
  assign src_val_s[0]  = bus.src_val0;
  assign src_val_s[1]  = bus.src_val1;
  assign src_val_s[2]  = bus.src_val2;
  assign src_addr_s[0] = bus.src_addr0;
  assign src_addr_s[1] = bus.src_addr1;
  assign src_addr_s[2] = bus.src_addr2;

  // Round-robin grant: first valid entry at or after rr_ptr_r, wrapping 2 -> 0
  always_comb begin
    grant_s = 3'b000;
    case (rr_ptr_r)
      2'd0: begin
        if (hold_valid_r[0])      grant_s = 3'b001;
        else if (hold_valid_r[1]) grant_s = 3'b010;
        else if (hold_valid_r[2]) grant_s = 3'b100;
        else                      grant_s = 3'b000;
      end
      2'd1: begin
        if (hold_valid_r[1])      grant_s = 3'b010;
        else if (hold_valid_r[2]) grant_s = 3'b100;
        else if (hold_valid_r[0]) grant_s = 3'b001;
        else                      grant_s = 3'b000;
      end
      2'd2: begin
        if (hold_valid_r[2])      grant_s = 3'b100;
        else if (hold_valid_r[0]) grant_s = 3'b001;
        else if (hold_valid_r[1]) grant_s = 3'b010;
        else                      grant_s = 3'b000;
      end
      default: grant_s = 3'b000;
    endcase
  end

  // Granted entry select and pointer advance past the winner
  always_comb begin
    sel_tag_s  = hold_tag_r[0];
    sel_val_s  = hold_val_r[0];
    sel_addr_s = hold_addr_r[0];
    rr_next_s  = rr_ptr_r;
    case (grant_s)
      3'b001: begin
        sel_tag_s  = hold_tag_r[0];
        sel_val_s  = hold_val_r[0];
        sel_addr_s = hold_addr_r[0];
        rr_next_s  = 2'd1;
      end
      3'b010: begin
        sel_tag_s  = hold_tag_r[1];
        sel_val_s  = hold_val_r[1];
        sel_addr_s = hold_addr_r[1];
        rr_next_s  = 2'd2;
      end
      3'b100: begin
        sel_tag_s  = hold_tag_r[2];
        sel_val_s  = hold_val_r[2];
        sel_addr_s = hold_addr_r[2];
        rr_next_s  = 2'd0;
      end
      default: rr_next_s = rr_ptr_r;
    endcase
  end

  // An entry being granted this cycle may be refilled on the same edge
  assign src_ready_s = {3{rdy_in & ~flush}} & (~hold_valid_r | grant_s);

  // Offers tagged None are consumed by the handshake but never stored
  always_comb begin
    accept_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      accept_s[i] = bus.src_valid[i] & src_ready_s[i] &
                    (src_tag_s[i] != {TAG_W{1'b0}});
    end
  end

  // Holding entries, round-robin pointer and broadcast registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hold_valid_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        hold_tag_r[i]  <= {TAG_W{1'b0}};
        hold_val_r[i]  <= {DATA_W{1'b0}};
        hold_addr_r[i] <= {DATA_W{1'b0}};
      end
      rr_ptr_r     <= 2'd0;
      cdb_active_r <= 1'b0;
      cdb_tag_r    <= {TAG_W{1'b0}};
      cdb_val_r    <= {DATA_W{1'b0}};
      cdb_addr_r   <= {DATA_W{1'b0}};
    end else if (rdy_in) begin
      if (flush) begin
        hold_valid_r <= 3'b000;
        rr_ptr_r     <= 2'd0;
        cdb_active_r <= 1'b0;
        cdb_tag_r    <= {TAG_W{1'b0}};
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (accept_s[i]) begin
            hold_valid_r[i] <= 1'b1;
            hold_tag_r[i]   <= src_tag_s[i];
            hold_val_r[i]   <= src_val_s[i];
            hold_addr_r[i]  <= src_addr_s[i];
          end else if (grant_s[i]) begin
            hold_valid_r[i] <= 1'b0;
          end else begin
            hold_valid_r[i] <= hold_valid_r[i];
          end
        end
        if (|grant_s) begin
          cdb_active_r <= 1'b1;
          cdb_tag_r    <= sel_tag_s;
          cdb_val_r    <= sel_val_s;
          cdb_addr_r   <= sel_addr_s;
          rr_ptr_r     <= rr_next_s;
        end else begin
          cdb_active_r <= 1'b0;
          cdb_tag_r    <= {TAG_W{1'b0}};
        end
      end
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign bus.src_ready  = src_ready_s;
  assign bus.cdb_active = cdb_active_r;
  assign bus.cdb_tag    = cdb_tag_r;
  assign bus.cdb_val    = cdb_val_r;
  assign bus.cdb_addr   = cdb_addr_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus randomized traffic.
// The driver applies stimulus on the falling edge, advances a behavioural
// model and pushes the expected bus state for the coming rising edge into a
// queue; an independent monitor pops and compares after every rising edge.
module tb_cdb_arbiter;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush;

  cdb_arbiter_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic              act;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] addr;
  } bus_t;

  bus_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // behavioural model state
  bit                m_valid [3];
  logic [TAG_W-1:0]  m_tag   [3];
  logic [DATA_W-1:0] m_val   [3];
  logic [DATA_W-1:0] m_addr  [3];
  int                m_rr;
  bus_t              m_bus;

  // stimulus state
  logic [2:0]        s_valid;
  logic [TAG_W-1:0]  s_tag  [3];
  logic [DATA_W-1:0] s_val  [3];
  logic [DATA_W-1:0] s_addr [3];
  logic              s_rdy;
  logic              s_flush;
  bit                s_cons [3];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      s_cons[i]  = 1'b1;
    end
    m_rr  = 0;
    m_bus = '{act: 1'b0, tag: '0, val: '0, addr: '0};
  endtask

  task automatic set_src(input int i, input logic v, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] va, input logic [DATA_W-1:0] ad);
    s_valid[i] = v;
    s_tag[i]   = t;
    s_val[i]   = va;
    s_addr[i]  = ad;
  endtask

  // Drive current stimulus, check src_ready, advance the model, push expectation
  task automatic apply_and_model();
    logic [2:0] er;
    int g;
    bus.src_valid = s_valid;
    bus.src_tag0  = s_tag[0];  bus.src_tag1  = s_tag[1];  bus.src_tag2  = s_tag[2];
    bus.src_val0  = s_val[0];  bus.src_val1  = s_val[1];  bus.src_val2  = s_val[2];
    bus.src_addr0 = s_addr[0]; bus.src_addr1 = s_addr[1]; bus.src_addr2 = s_addr[2];
    rdy_in = s_rdy;
    flush  = s_flush;
    #1;
    er = 3'b000;
    g  = -1;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_rr + k) % 3;
      if (g < 0 && m_valid[idx]) g = idx;
    end
    if (s_rdy && !s_flush) begin
      for (int i = 0; i < 3; i++) er[i] = !m_valid[i] || (g == i);
    end
    check("src_ready", {29'd0, bus.src_ready}, {29'd0, er});
    for (int i = 0; i < 3; i++) s_cons[i] = s_valid[i] && er[i];
    if (s_rdy) begin
      if (s_flush) begin
        for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
        m_rr = 0;
        m_bus.act = 1'b0;
        m_bus.tag = '0;
      end else begin
        if (g >= 0) begin
          m_bus.act  = 1'b1;
          m_bus.tag  = m_tag[g];
          m_bus.val  = m_val[g];
          m_bus.addr = m_addr[g];
          m_valid[g] = 1'b0;
          m_rr = (g + 1) % 3;
        end else begin
          m_bus.act = 1'b0;
          m_bus.tag = '0;
        end
        for (int i = 0; i < 3; i++) begin
          if (s_cons[i] && s_tag[i] != '0) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = s_tag[i];
            m_val[i]   = s_val[i];
            m_addr[i]  = s_addr[i];
          end
        end
      end
    end
    exp_q.push_back(m_bus);
  endtask

  task automatic cycle();
    @(negedge clk_in);
    apply_and_model();
  endtask

  task automatic idle(input int n);
    s_valid = 3'b000; s_rdy = 1'b1; s_flush = 1'b0;
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    apply_and_model();
  endtask

  // Sources keep an unconsumed offer; otherwise draw a fresh random one
  task automatic gen_offers();
    for (int i = 0; i < 3; i++) begin
      if (s_cons[i] || !s_valid[i]) begin
        s_valid[i] = ($urandom_range(0, 2) != 0);
        s_tag[i]   = TAG_W'($urandom_range(0, 15));
        s_val[i]   = $urandom;
        s_addr[i]  = $urandom;
      end
    end
  endtask

  // Monitor: compare the bus after every rising edge outside reset
  initial begin
    bus_t e;
    forever begin
      @(posedge clk_in);
      if (!rst_in) begin
        #1;
        if (exp_q.size() == 0) begin
          check("expect_queue_nonempty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("cdb_active", {31'd0, bus.cdb_active}, {31'd0, e.act});
          check("cdb_tag", {28'd0, bus.cdb_tag}, {28'd0, e.tag});
          check("cdb_val", bus.cdb_val, e.val);
          check("cdb_addr", bus.cdb_addr, e.addr);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b1;
    s_rdy = 1'b1; s_flush = 1'b0; s_valid = 3'b000;
    for (int i = 0; i < 3; i++) set_src(i, 1'b0, '0, '0, '0);
    model_reset();
    bus.src_valid = 3'b000;
    bus.src_tag0 = '0; bus.src_tag1 = '0; bus.src_tag2 = '0;
    bus.src_val0 = '0; bus.src_val1 = '0; bus.src_val2 = '0;
    bus.src_addr0 = '0; bus.src_addr1 = '0; bus.src_addr2 = '0;
    rdy_in = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk_in);
    #2;
    check("reset_active", {31'd0, bus.cdb_active}, 32'd0);
    check("reset_tag", {28'd0, bus.cdb_tag}, 32'd0);
    check("reset_val", bus.cdb_val, 32'd0);
    check("reset_addr", bus.cdb_addr, 32'd0);
    check("reset_ready", {29'd0, bus.src_ready}, 32'd7);
    release_reset();

    // single source, one-cycle latency
    set_src(0, 1'b1, 4'd3, 32'h11, 32'h100);
    cycle();
    idle(3);

    // flush to rr_ptr 0, then three-way contention
    s_flush = 1'b1; cycle(); s_flush = 1'b0;
    set_src(0, 1'b1, 4'd1, 32'hA1, 32'h200);
    set_src(1, 1'b1, 4'd2, 32'hA2, 32'h204);
    set_src(2, 1'b1, 4'd3, 32'hA3, 32'h208);
    cycle();
    idle(4);

    // back-to-back refill on source 1
    for (int k = 1; k <= 8; k++) begin
      s_valid = 3'b000;
      set_src(1, 1'b1, TAG_W'(k), 32'h1000 + k, 32'h2000 + k);
      cycle();
    end
    idle(2);

    // stall with two held entries, offers present while stalled
    s_valid = 3'b000;
    set_src(0, 1'b1, 4'd5, 32'h55, 32'h500);
    set_src(2, 1'b1, 4'd6, 32'h66, 32'h600);
    cycle();
    set_src(1, 1'b1, 4'd9, 32'h99, 32'h900);
    s_rdy = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    idle(4);

    // flush with two held entries
    set_src(0, 1'b1, 4'd7, 32'h77, 32'h700);
    set_src(1, 1'b1, 4'd8, 32'h88, 32'h800);
    cycle();
    s_valid = 3'b000; s_flush = 1'b1; cycle(); s_flush = 1'b0;
    idle(3);

    // None tag is consumed but never broadcast
    set_src(2, 1'b1, 4'd0, 32'hDEAD, 32'hBEEF);
    cycle();
    idle(2);

    // asynchronous reset while the bus is active
    set_src(2, 1'b1, 4'd9, 32'h9, 32'h90);
    set_src(0, 1'b1, 4'd4, 32'h4, 32'h40);
    cycle();
    s_valid = 3'b000;
    cycle();
    @(posedge clk_in);
    #2;
    check("pre_reset_active", {31'd0, bus.cdb_active}, 32'd1);
    #1;
    rst_in = 1'b1;
    #1;
    check("async_reset_active", {31'd0, bus.cdb_active}, 32'd0);
    check("async_reset_tag", {28'd0, bus.cdb_tag}, 32'd0);
    exp_q.delete();
    @(posedge clk_in);
    release_reset();
    idle(3);

    // randomized traffic with stalls and flushes
    for (int c = 0; c < 400; c++) begin
      gen_offers();
      s_rdy   = ($urandom_range(0, 7) != 0);
      s_flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    idle(6);
    @(posedge clk_in);
    #3;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
